// File: rtl/frame_stack_if.sv
// Frame-context bus between the control unit / register file and the call-frame stack.
// The master side issues push/pop and supplies frames; the slave side is the stack.
interface frame_stack_if #(
    parameter int FRAME_W = 256,
    parameter int PTR_W   = 4
);
    logic               push;
    logic               pop;
    logic               clr_err;
    logic [FRAME_W-1:0] frame_in;
    logic [FRAME_W-1:0] frame_out;
    logic               restore;
    logic               busy;
    logic [PTR_W:0]     depth;
    logic               full;
    logic               empty;
    logic               overflow;
    logic               underflow;
    logic               conflict;

    modport master (
        output push, pop, clr_err, frame_in,
        input  frame_out, restore, busy, depth, full, empty,
               overflow, underflow, conflict
    );

    modport slave (
        input  push, pop, clr_err, frame_in,
        output frame_out, restore, busy, depth, full, empty,
               overflow, underflow, conflict
    );
endinterface

// File: rtl/frame_stack.sv
// Call-frame context stack: saves register-file frames on push and replays them
// on pop, finishing each pop with a one-cycle restore strobe to the register file.
module frame_stack #(
    parameter int FRAME_W = 256,
    parameter int DEPTH   = 16,
    parameter int PTR_W   = 4
) (
    input  logic          clk,
    input  logic          reset,
    frame_stack_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        POP_RD  = 2'd1,
        POP_RST = 2'd2
    } state_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    // Sticky error flag indices
    localparam int ERR_OVF = 0;
    localparam int ERR_UNF = 1;
    localparam int ERR_CFL = 2;
    localparam int N_ERR   = 3;

    state_t             state_reg;
    logic [PTR_W:0]     sp_reg;
    logic [FRAME_W-1:0] frame_out_reg;
    logic               restore_reg;
    logic               busy_reg;
    logic [N_ERR-1:0]   err_reg;
    logic [N_ERR-1:0]   err_set;

    logic [FRAME_W-1:0] mem [DEPTH];

    logic in_idle;
    logic push_only;
    logic pop_only;
    logic full_w;
    logic empty_w;
    logic wr_en;
    logic rd_start;

    assign full_w    = (sp_reg == FULL_CNT);
    assign empty_w   = (sp_reg == '0);
    assign in_idle   = (state_reg == IDLE);
    assign push_only = bus.push & ~bus.pop;
    assign pop_only  = bus.pop & ~bus.push;

    assign wr_en    = in_idle & push_only & ~full_w;
    assign rd_start = in_idle & pop_only & ~empty_w;

    // Requests arriving while a pop is in flight are dropped without flagging.
    assign err_set[ERR_OVF] = in_idle & push_only & full_w;
    assign err_set[ERR_UNF] = in_idle & pop_only & empty_w;
    assign err_set[ERR_CFL] = in_idle & bus.push & bus.pop;

    // Frame storage is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[sp_reg[PTR_W-1:0]] <= bus.frame_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            sp_reg        <= '0;
            frame_out_reg <= '0;
            restore_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            restore_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (wr_en) begin
                        sp_reg <= sp_reg + 1'b1;
                    end else if (rd_start) begin
                        sp_reg    <= sp_reg - 1'b1;
                        busy_reg  <= 1'b1;
                        state_reg <= POP_RD;
                    end
                end
                POP_RD: begin
                    // sp already points at the frame being returned
                    frame_out_reg <= mem[sp_reg[PTR_W-1:0]];
                    state_reg     <= POP_RST;
                end
                POP_RST: begin
                    restore_reg <= 1'b1;
                    busy_reg    <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    genvar gi;
    generate
        for (gi = 0; gi < N_ERR; gi++) begin : g_err
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    err_reg[gi] <= 1'b0;
                end else if (err_set[gi]) begin
                    err_reg[gi] <= 1'b1;
                end else if (bus.clr_err) begin
                    err_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign bus.frame_out = frame_out_reg;
    assign bus.restore   = restore_reg;
    assign bus.busy      = busy_reg;
    assign bus.depth     = sp_reg;
    assign bus.full      = full_w;
    assign bus.empty     = empty_w;
    assign bus.overflow  = err_reg[ERR_OVF];
    assign bus.underflow = err_reg[ERR_UNF];
    assign bus.conflict  = err_reg[ERR_CFL];
endmodule

// File: tb/tb_frame_stack.sv
// Directed bench for frame_stack: push/pop ordering, restore timing, error flags, reset mid-pop.
module tb_frame_stack;
    localparam int FRAME_W = 256;
    localparam int DEPTH   = 16;
    localparam int PTR_W   = 4;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    frame_stack_if #(.FRAME_W(FRAME_W), .PTR_W(PTR_W)) bus ();

    frame_stack #(.FRAME_W(FRAME_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [FRAME_W-1:0] frame_of(input int i);
        logic [FRAME_W-1:0] f;
        for (int r = 0; r < 16; r++) begin
            f[r*16 +: 16] = (r == 0) ? 16'(i) : 16'(i * 257 + r * 16'h1000);
        end
        return f;
    endfunction

    task automatic push_frame(input logic [FRAME_W-1:0] f);
        bus.frame_in = f;
        bus.push     = 1'b1;
        @(posedge clk); #1;
        bus.push     = 1'b0;
    endtask

    // Issues one pop and watches the next five cycles (bounded).
    task automatic do_pop(output logic [FRAME_W-1:0] got, output int restores,
                          output int busy_cycles, output int restore_at);
        got = '0; restores = 0; busy_cycles = 0; restore_at = -1;
        bus.pop = 1'b1;
        @(posedge clk); #1;
        bus.pop = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.restore === 1'b1) begin
                restores++;
                got        = bus.frame_out;
                restore_at = c;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0; bus.frame_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0; bus.frame_in = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (bus.depth !== 5'd0) begin fails++; $display("FAIL reset_depth: got %0d expected 0", bus.depth); end
        tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        tests++; if (bus.frame_out !== '0) begin fails++; $display("FAIL reset_frame_out: got %h expected 0", bus.frame_out); end
        tests++; if ({bus.restore, bus.busy, bus.overflow, bus.underflow, bus.conflict} !== 5'b0) begin
            fails++; $display("FAIL reset_flags: got %b expected 00000",
                              {bus.restore, bus.busy, bus.overflow, bus.underflow, bus.conflict});
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_push_one();
        push_frame({16{16'h1111}});
        tests++; if (bus.depth !== 5'd1) begin fails++; $display("FAIL push1_depth: got %0d expected 1", bus.depth); end
        tests++; if (bus.empty !== 1'b0) begin fails++; $display("FAIL push1_empty: got %b expected 0", bus.empty); end
        tests++; if (bus.restore !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL push1_strobes: got restore=%b busy=%b expected 0 0", bus.restore, bus.busy);
        end
    endtask

    task automatic test_pop_order();
        logic [FRAME_W-1:0] got;
        int rs, bc, ra;
        apply_reset();
        push_frame({16{16'hAAAA}});
        push_frame({16{16'h5555}});
        do_pop(got, rs, bc, ra);
        tests++; if (bc !== 2) begin fails++; $display("FAIL popB_busy_cycles: got %0d expected 2", bc); end
        tests++; if (rs !== 1) begin fails++; $display("FAIL popB_restore_count: got %0d expected 1", rs); end
        tests++; if (ra !== 2) begin fails++; $display("FAIL popB_restore_latency: got %0d expected 2", ra); end
        tests++; if (got !== {16{16'h5555}}) begin fails++; $display("FAIL popB_frame: got %h expected %h", got, {16{16'h5555}}); end
        tests++; if (bus.frame_out !== {16{16'h5555}}) begin fails++; $display("FAIL popB_hold: got %h expected %h", bus.frame_out, {16{16'h5555}}); end
        do_pop(got, rs, bc, ra);
        tests++; if (got !== {16{16'hAAAA}} || rs !== 1) begin
            fails++; $display("FAIL popA_frame: got %h (restores %0d) expected %h (1)", got, rs, {16{16'hAAAA}});
        end
        tests++; if (bus.depth !== 5'd0 || bus.empty !== 1'b1) begin
            fails++; $display("FAIL popA_empty: got depth=%0d empty=%b expected 0 1", bus.depth, bus.empty);
        end
    endtask

    task automatic test_fill_drain();
        logic [FRAME_W-1:0] got;
        int rs, bc, ra;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) push_frame(frame_of(i));
        tests++; if (bus.full !== 1'b1 || bus.depth !== 5'd16) begin
            fails++; $display("FAIL fill_full: got full=%b depth=%0d expected 1 16", bus.full, bus.depth);
        end
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL fill_no_overflow: got %b expected 0", bus.overflow); end
        push_frame(frame_of(99));
        tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL overflow_flag: got %b expected 1", bus.overflow); end
        tests++; if (bus.depth !== 5'd16) begin fails++; $display("FAIL overflow_depth: got %0d expected 16", bus.depth); end
        for (int k = 0; k < DEPTH; k++) begin
            do_pop(got, rs, bc, ra);
            tests++; if (got !== frame_of(DEPTH - 1 - k) || rs !== 1) begin
                fails++; $display("FAIL drain_%0d: got %h (restores %0d) expected %h (1)", k, got, rs, frame_of(DEPTH - 1 - k));
            end
        end
        tests++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            fails++; $display("FAIL drain_empty: got empty=%b full=%b expected 1 0", bus.empty, bus.full);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        bus.pop = 1'b1;
        @(posedge clk); #1;
        bus.pop = 1'b0;
        tests++; if (bus.underflow !== 1'b1) begin fails++; $display("FAIL underflow_flag: got %b expected 1", bus.underflow); end
        tests++; if (bus.busy !== 1'b0 || bus.depth !== 5'd0) begin
            fails++; $display("FAIL underflow_busy: got busy=%b depth=%0d expected 0 0", bus.busy, bus.depth);
        end
        repeat (3) begin
            tests++; if (bus.restore !== 1'b0) begin fails++; $display("FAIL underflow_restore: got %b expected 0", bus.restore); end
            @(posedge clk); #1;
        end
        bus.clr_err = 1'b1;
        @(posedge clk); #1;
        bus.clr_err = 1'b0;
        tests++; if (bus.underflow !== 1'b0) begin fails++; $display("FAIL clr_underflow: got %b expected 0", bus.underflow); end
        bus.clr_err = 1'b1; bus.pop = 1'b1;
        @(posedge clk); #1;
        bus.clr_err = 1'b0; bus.pop = 1'b0;
        tests++; if (bus.underflow !== 1'b1) begin fails++; $display("FAIL clr_vs_error: got %b expected 1", bus.underflow); end
    endtask

    task automatic test_conflict_busy();
        apply_reset();
        for (int i = 0; i < 3; i++) push_frame(frame_of(40 + i));
        bus.push = 1'b1; bus.pop = 1'b1; bus.frame_in = frame_of(77);
        @(posedge clk); #1;
        bus.push = 1'b0; bus.pop = 1'b0;
        tests++; if (bus.depth !== 5'd3) begin fails++; $display("FAIL conflict_depth: got %0d expected 3", bus.depth); end
        tests++; if (bus.conflict !== 1'b1 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL conflict_flag: got conflict=%b busy=%b expected 1 0", bus.conflict, bus.busy);
        end
        bus.clr_err = 1'b1;
        @(posedge clk); #1;
        bus.clr_err = 1'b0;
        tests++; if (bus.conflict !== 1'b0) begin fails++; $display("FAIL clr_conflict: got %b expected 0", bus.conflict); end
        bus.pop = 1'b1;
        @(posedge clk); #1;
        bus.pop = 1'b0;
        bus.push = 1'b1; bus.frame_in = frame_of(88);
        repeat (2) @(posedge clk);
        #1;
        bus.push = 1'b0;
        tests++; if (bus.restore !== 1'b1) begin fails++; $display("FAIL busy_push_restore: got %b expected 1", bus.restore); end
        tests++; if (bus.depth !== 5'd2) begin fails++; $display("FAIL busy_push_depth: got %0d expected 2", bus.depth); end
        tests++; if ({bus.overflow, bus.underflow, bus.conflict} !== 3'b000) begin
            fails++; $display("FAIL busy_push_flags: got %b expected 000", {bus.overflow, bus.underflow, bus.conflict});
        end
        tests++; if (bus.frame_out !== frame_of(42)) begin fails++; $display("FAIL busy_push_frame: got %h expected %h", bus.frame_out, frame_of(42)); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [FRAME_W-1:0] got;
        int rs, bc, ra;
        apply_reset();
        push_frame(frame_of(5));
        bus.pop = 1'b1;
        @(posedge clk); #1;
        bus.pop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Restore cycle: FSM is back in IDLE, so this push reuses the slot just returned.
        bus.push = 1'b1; bus.frame_in = frame_of(6);
        @(posedge clk); #1;
        bus.push = 1'b0;
        tests++; if (bus.depth !== 5'd1) begin fails++; $display("FAIL b2b_depth: got %0d expected 1", bus.depth); end
        do_pop(got, rs, bc, ra);
        tests++; if (got !== frame_of(6) || rs !== 1) begin
            fails++; $display("FAIL b2b_frame: got %h (restores %0d) expected %h (1)", got, rs, frame_of(6));
        end
    endtask

    task automatic test_reset_mid_pop();
        int rs;
        apply_reset();
        push_frame(frame_of(11));
        push_frame(frame_of(12));
        bus.pop = 1'b1;
        @(posedge clk); #1;
        bus.pop = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        tests++; if (bus.restore !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL midpop_strobes: got restore=%b busy=%b expected 0 0", bus.restore, bus.busy);
        end
        tests++; if (bus.depth !== 5'd0 || bus.empty !== 1'b1) begin
            fails++; $display("FAIL midpop_depth: got depth=%0d empty=%b expected 0 1", bus.depth, bus.empty);
        end
        tests++; if (bus.frame_out !== '0) begin fails++; $display("FAIL midpop_frame_out: got %h expected 0", bus.frame_out); end
        @(negedge clk);
        reset = 1'b0;
        rs = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.restore === 1'b1) rs++;
        end
        tests++; if (rs !== 0) begin fails++; $display("FAIL midpop_lost_restore: got %0d pulses expected 0", rs); end
        tests++; if (bus.busy !== 1'b0 || bus.depth !== 5'd0) begin
            fails++; $display("FAIL midpop_after: got busy=%b depth=%0d expected 0 0", bus.busy, bus.depth);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_push_one();
        test_pop_order();
        test_fill_drain();
        test_underflow();
        test_conflict_busy();
        test_back_to_back();
        test_reset_mid_pop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
